// File: rtl/move_sequencer.sv
// Tick-paced movement sequencer for a grid maze: on each step it looks up the
// legal exits of the current cell, picks a direction and advances one cell.
`timescale 1ns/1ps
module move_sequencer #(
    parameter int TICKS_PER_STEP = 4000000,
    parameter int CNT_W          = 22,
    parameter int GRID_W         = 28,
    parameter int GRID_H         = 31,
    parameter int START_X        = 13,
    parameter int START_Y        = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req_dir,
    output logic       legal_req,
    output logic [4:0] legal_x,
    output logic [4:0] legal_y,
    input  logic       legal_ack,
    input  logic [3:0] legal_moves,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [3:0] move_dir,
    output logic       step_done,
    output logic       blocked
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECIDE = 2'd2,
        S_MOVE   = 2'd3
    } state_t;

    localparam logic [3:0]       DIR_L    = 4'b0001;
    localparam logic [3:0]       DIR_R    = 4'b0010;
    localparam logic [3:0]       DIR_U    = 4'b0100;
    localparam logic [3:0]       DIR_D    = 4'b1000;
    localparam logic [4:0]       X_MAX    = 5'(GRID_W - 1);
    localparam logic [4:0]       Y_MAX    = 5'(GRID_H - 1);
    localparam logic [4:0]       X_RST    = 5'(START_X);
    localparam logic [4:0]       Y_RST    = 5'(START_Y);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [4:0]       pos_x_q,     pos_x_d;
    logic [4:0]       pos_y_q,     pos_y_d;
    logic [3:0]       dir_q,       dir_d;
    logic [3:0]       moves_q,     moves_d;
    logic             req_q,       req_d;
    logic [4:0]       lx_q,        lx_d;
    logic [4:0]       ly_q,        ly_d;
    logic             done_q,      done_d;
    logic             blocked_q,   blocked_d;
    logic             tick_s;
    logic             req_valid_s;

    // Zero or multiple request bits are treated as "no request".
    function automatic logic is_onehot4(input logic [3:0] v);
        logic r;
        case (v)
            DIR_L, DIR_R, DIR_U, DIR_D: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] next_x(input logic [4:0] x, input logic [3:0] dir);
        logic [4:0] r;
        case (dir)
            DIR_L:   r = (x == 5'd0)  ? X_MAX : x - 5'd1;
            DIR_R:   r = (x == X_MAX) ? 5'd0  : x + 5'd1;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] next_y(input logic [4:0] y, input logic [3:0] dir);
        logic [4:0] r;
        case (dir)
            DIR_U:   r = (y == 5'd0)  ? Y_MAX : y - 5'd1;
            DIR_D:   r = (y == Y_MAX) ? 5'd0  : y + 5'd1;
            default: r = y;
        endcase
        return r;
    endfunction

    assign tick_s      = enable && (cnt_q == CNT_LAST);
    assign req_valid_s = is_onehot4(req_dir) && ((req_dir & moves_q) != 4'b0000);

    // Step-rate counter: free-runs while enabled, held at zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_d     = dir_q;
        moves_d   = moves_q;
        req_d     = req_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        done_d    = 1'b0;
        blocked_d = blocked_q;
        case (state_q)
            S_IDLE: begin
                // Ticks arriving outside IDLE are simply lost.
                if (tick_s) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    lx_d    = pos_x_q;
                    ly_d    = pos_y_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (legal_ack) begin
                    moves_d = legal_moves;
                    req_d   = 1'b0;
                    state_d = S_DECIDE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DECIDE: begin
                if (req_valid_s) begin
                    dir_d   = req_dir;
                    state_d = S_MOVE;
                end else if ((dir_q & moves_q) != 4'b0000) begin
                    state_d = S_MOVE;
                end else begin
                    blocked_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_MOVE: begin
                pos_x_d   = next_x(pos_x_q, dir_q);
                pos_y_d   = next_y(pos_y_q, dir_q);
                blocked_d = 1'b0;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any step in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pos_x_q   <= X_RST;
            pos_y_q   <= Y_RST;
            dir_q     <= DIR_L;
            moves_q   <= 4'b0000;
            req_q     <= 1'b0;
            lx_q      <= X_RST;
            ly_q      <= Y_RST;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_q     <= dir_d;
            moves_q   <= moves_d;
            req_q     <= req_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
        end
    end

    assign legal_req = req_q;
    assign legal_x   = lx_q;
    assign legal_y   = ly_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign move_dir  = dir_q;
    assign step_done = done_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a short step period (4 clocks).
`timescale 1ns/1ps
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req_dir;
    logic       legal_req;
    logic [4:0] legal_x;
    logic [4:0] legal_y;
    logic       legal_ack;
    logic [3:0] legal_moves;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [3:0] move_dir;
    logic       step_done;
    logic       blocked;

    int total = 0;
    int bad   = 0;
    int exp_x = 13;
    int exp_y = 23;

    move_sequencer #(
        .TICKS_PER_STEP(4),
        .CNT_W         (3),
        .GRID_W        (28),
        .GRID_H        (31),
        .START_X       (13),
        .START_Y       (23)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_dir    (req_dir),
        .legal_req  (legal_req),
        .legal_x    (legal_x),
        .legal_y    (legal_y),
        .legal_ack  (legal_ack),
        .legal_moves(legal_moves),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .move_dir   (move_dir),
        .step_done  (step_done),
        .blocked    (blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int x, input int y,
                                input logic [3:0] dir, input logic blk);
        check({tag, "_x"},   32'(pos_x),    32'(x));
        check({tag, "_y"},   32'(pos_y),    32'(y));
        check({tag, "_dir"}, 32'(move_dir), 32'(dir));
        check({tag, "_blk"}, 32'(blocked),  32'(blk));
    endtask

    // One step: wait for the lookup, hold ack off for 'delay' cycles, then
    // acknowledge and measure edges from lookup start to the step_done pulse.
    task automatic do_step(input logic [3:0] rd, input logic [3:0] mv, input int delay,
                           input bit moves, input bit drop_en, input string tag);
        int  n;
        bit  seen;
        req_dir     = rd;
        legal_moves = mv;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (legal_req) seen = 1'b1;
        end
        check({tag, "_req_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, "_lx"}, 32'(legal_x), 32'(exp_x));
        check({tag, "_ly"}, 32'(legal_y), 32'(exp_y));
        n = 0;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            n++;
            check({tag, "_req_hold"}, 32'(legal_req), 32'd1);
            check({tag, "_lx_hold"},  32'(legal_x),   32'(exp_x));
            check({tag, "_ly_hold"},  32'(legal_y),   32'(exp_y));
            check({tag, "_no_done"},  32'(step_done), 32'd0);
        end
        legal_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (i == 0) begin
                legal_ack = 1'b0;
                check({tag, "_req_drop"}, 32'(legal_req), 32'd0);
                if (drop_en) enable = 1'b0;
            end
            if (step_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(delay + (moves ? 3 : 2)));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(step_done), 32'd0);
    endtask

    initial begin
        int  req_cnt;
        int  done_cnt;
        bit  seen;
        reset       = 1'b1;
        enable      = 1'b0;
        req_dir     = 4'b0000;
        legal_ack   = 1'b0;
        legal_moves = 4'b0000;
        #3;
        expect_state("rst", 13, 23, 4'b0001, 1'b0);
        check("rst_req",  32'(legal_req), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);
        check("rst_lx",   32'(legal_x),   32'd13);
        check("rst_ly",   32'(legal_y),   32'd23);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        do_step(4'b0010, 4'b1111, 0, 1'b1, 1'b0, "right");
        exp_x = 14;
        expect_state("right", exp_x, exp_y, 4'b0010, 1'b0);

        do_step(4'b0001, 4'b1111, 0, 1'b1, 1'b0, "left");
        exp_x = 13;
        expect_state("left", exp_x, exp_y, 4'b0001, 1'b0);

        do_step(4'b0100, 4'b0001, 0, 1'b1, 1'b0, "keep");
        exp_x = 12;
        expect_state("keep", exp_x, exp_y, 4'b0001, 1'b0);

        do_step(4'b0001, 4'b0000, 0, 1'b0, 1'b0, "wall");
        expect_state("wall", exp_x, exp_y, 4'b0001, 1'b1);

        do_step(4'b0011, 4'b0010, 0, 1'b0, 1'b0, "multi");
        expect_state("multi", exp_x, exp_y, 4'b0001, 1'b1);

        for (int i = 0; i < 12; i++) begin
            do_step(4'b0001, 4'b0001, 0, 1'b1, 1'b0, "walk_l");
            exp_x = exp_x - 1;
        end
        expect_state("at_x0", 0, 23, 4'b0001, 1'b0);

        do_step(4'b0001, 4'b0001, 0, 1'b1, 1'b0, "wrap_l");
        exp_x = 27;
        expect_state("wrap_l", 27, 23, 4'b0001, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_step(4'b1000, 4'b1000, 0, 1'b1, 1'b0, "walk_d");
            exp_y = exp_y + 1;
        end
        expect_state("at_y30", 27, 30, 4'b1000, 1'b0);

        do_step(4'b1000, 4'b1000, 0, 1'b1, 1'b0, "wrap_d");
        exp_y = 0;
        expect_state("wrap_d", 27, 0, 4'b1000, 1'b0);

        do_step(4'b0000, 4'b1111, 10, 1'b1, 1'b1, "slow");
        exp_y = 1;
        expect_state("slow", 27, 1, 4'b1000, 1'b0);
        req_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (legal_req) req_cnt++;
            if (step_done) done_cnt++;
        end
        check("idle_no_req",  32'(req_cnt),  32'd0);
        check("idle_no_done", 32'(done_cnt), 32'd0);

        enable  = 1'b1;
        req_dir = 4'b0010;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (legal_req) seen = 1'b1;
        end
        check("midreq_seen", 32'(seen), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_req", 32'(legal_req), 32'd0);
        expect_state("midrst", 13, 23, 4'b0001, 1'b0);
        check("midrst_lx", 32'(legal_x), 32'd13);
        @(posedge clk); #1;
        check("midrst_hold_req", 32'(legal_req), 32'd0);
        check("midrst_hold_done", 32'(step_done), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_STEP, default 4000000: clk cycles per movement step.
REQ-002 The block SHALL have parameter CNT_W, default 22: tick counter width.
REQ-003 The block SHALL have parameter GRID_W, default 28: maze columns.
REQ-004 The block SHALL have parameter GRID_H, default 31: maze rows.
REQ-005 The block SHALL have parameter START_X, default 13: reset column.
REQ-006 The block SHALL have parameter START_Y, default 23: reset row.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port enable, input, 1 bit: game running.
REQ-010 The block SHALL have port req_dir, input, 4 bits: requested direction, one-hot (0001 left, 0010 right, 0100 up, 1000 down).
REQ-011 The block SHALL have port legal_req, output, 1 bit: legal-move lookup request.
REQ-012 The block SHALL have port legal_x, output, 5 bits: lookup column.
REQ-013 The block SHALL have port legal_y, output, 5 bits: lookup row.
REQ-014 The block SHALL have port legal_ack, input, 1 bit: lookup complete; legal_moves valid this cycle.
REQ-015 The block SHALL have port legal_moves, input, 4 bits: legal directions at the lookup cell, same bit order as req_dir.
REQ-016 The block SHALL have port pos_x, output, 5 bits: current column.
REQ-017 The block SHALL have port pos_y, output, 5 bits: current row.
REQ-018 The block SHALL have port move_dir, output, 4 bits: committed direction, one-hot.
REQ-019 The block SHALL have port step_done, output, 1 bit: one-cycle pulse at the end of each step.
REQ-020 The block SHALL have port blocked, output, 1 bit: the last step made no move.

Function
REQ-021 Tick counter: while enable=1, count 0..TICKS_PER_STEP-1 and wrap to 0; a tick is the cycle at count TICKS_PER_STEP-1.
REQ-022 Tick counter: while enable=0, clear to 0 and generate no ticks.
REQ-023 FSM states SHALL be IDLE, REQ, DECIDE, MOVE; all outputs are registered.
REQ-024 IDLE: on a tick go to REQ; ticks in any other state are dropped, never queued.
REQ-025 REQ: legal_req=1, legal_x/legal_y=pos_x/pos_y held stable; on the cycle legal_ack=1, capture legal_moves, go to DECIDE, and drop legal_req on the next edge.
REQ-026 REQ: no timeout; wait indefinitely for legal_ack; legal_ack outside REQ is ignored.
REQ-027 DECIDE: if req_dir is exactly one-hot and its bit is set in the captured moves, move_dir<=req_dir, go to MOVE.
REQ-028 DECIDE: else if the move_dir bit is set in the captured moves, keep move_dir, go to MOVE.
REQ-029 DECIDE: else blocked<=1, step_done<=1, pos and move_dir unchanged, go to IDLE.
REQ-030 req_dir of 0000 or with more than one bit set SHALL be treated as no request.
REQ-031 MOVE: left x-1, right x+1, up y-1, down y+1.
REQ-032 MOVE wrap-around: left at x=0 gives GRID_W-1; right at GRID_W-1 gives 0; up at y=0 gives GRID_H-1; down at GRID_H-1 gives 0.
REQ-033 MOVE: new pos, blocked<=0 and step_done<=1 SHALL all take effect on the edge leaving MOVE; then go to IDLE.
REQ-034 step_done SHALL be high for exactly one cycle per step.
REQ-035 Latency: with legal_ack in the first REQ cycle, step_done and the new pos SHALL appear 3 cycles after the tick cycle.
REQ-036 enable falling mid-step: the current step SHALL complete; no new step starts.

Reset
REQ-037 On reset=1, asynchronously: state IDLE, counter 0, pos=(START_X,START_Y), move_dir=0001, legal_req=0, legal_x/legal_y=START, step_done=0, blocked=0.
REQ-038 Reset mid-step SHALL abort the lookup immediately (legal_req low); no pending step SHALL be kept.

Verification
REQ-039 TICKS_PER_STEP=4, req_dir=0010, legal_moves=1111, ack immediate -> pos_x 13 to 14, move_dir=0010, step_done 3 cycles after tick.
REQ-040 req_dir=0100 illegal, legal_moves=0001, move_dir=0001 -> move_dir stays 0001, pos_x-1, blocked=0.
REQ-041 legal_moves=0000 -> blocked=1, step_done pulse, pos unchanged.
REQ-042 pos_x=0, dir left legal -> pos_x=27; pos_y=30, down legal -> pos_y=0.
REQ-043 Hold legal_ack low 10 cycles -> legal_req and legal_x/legal_y stable, extra ticks dropped, exactly one step_done.
REQ-044 Assert reset while in REQ -> legal_req=0 at once, pos=(13,23), move_dir=0001.
